// File: rtl/score_keeper.sv
// Pong score keeper: tracks both scores, sequences IDLE/PLAY/HOLD/GAME_OVER and drives the display word.
// Optional feature macro SCORE_BLINK_EN: blink the display word while in GAME_OVER.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        point_left,
  input  logic        point_right,
  output logic [3:0]  left_score,
  output logic [3:0]  right_score,
  output logic [11:0] display_data,
  output logic        ball_reset,
  output logic        serve_left,
  output logic        game_over,
  output logic        winner
);

  localparam int               CNT_W     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, GAME_OVER} state_t;

  state_t           state_q, state_d;
  logic [3:0]       left_q, left_d;
  logic [3:0]       right_q, right_d;
  logic             serve_left_q, serve_left_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [11:0]      display_q, display_d;
  logic [11:0]      score_word;

  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    right_d      = right_q;
    serve_left_d = serve_left_q;
    winner_d     = winner_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = PLAY;
      end
      PLAY: begin
        if (point_left && point_right) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else if (point_left) begin
          if (left_q != WIN) left_d = left_q + 4'd1;
          serve_left_d = 1'b0;
          if (left_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = 1'b0;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end else if (point_right) begin
          if (right_q != WIN) right_d = right_q + 4'd1;
          serve_left_d = 1'b1;
          if (right_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = 1'b1;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = PLAY;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_d  = PLAY;
          left_d   = 4'd0;
          right_d  = 4'd0;
          winner_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Built from next-state scores so the registered display never lags the score outputs.
  always_comb begin
    score_word = ({8'd0, left_d} << 6) + ({8'd0, left_d} << 5)
               + ({8'd0, left_d} << 2) + {8'd0, right_d};
  end

`ifdef SCORE_BLINK_EN
  localparam int               BLINK_W    = $clog2(BLINK_CYCLES) + 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  // Phase restarts (score shown first) whenever GAME_OVER is entered or left.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (state_d != GAME_OVER || state_q != GAME_OVER) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
    display_d = blink_off_d ? 12'd0 : score_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`else
  always_comb begin
    display_d = score_word;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      left_q       <= 4'd0;
      right_q      <= 4'd0;
      serve_left_q <= 1'b0;
      winner_q     <= 1'b0;
      hold_cnt_q   <= '0;
      display_q    <= 12'd0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      right_q      <= right_d;
      serve_left_q <= serve_left_d;
      winner_q     <= winner_d;
      hold_cnt_q   <= hold_cnt_d;
      display_q    <= display_d;
    end
  end

  assign left_score   = left_q;
  assign right_score  = right_q;
  assign display_data = display_q;
  assign ball_reset   = (state_q != PLAY);
  assign serve_left   = serve_left_q;
  assign game_over    = (state_q == GAME_OVER);
  assign winner       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (WIN_SCORE=7, HOLD_CYCLES=4, BLINK_CYCLES=3).
module tb_score_keeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic        point_left;
  logic        point_right;
  logic [3:0]  left_score;
  logic [3:0]  right_score;
  logic [11:0] display_data;
  logic        ball_reset;
  logic        serve_left;
  logic        game_over;
  logic        winner;

  int passCount  = 0;
  int totalCount = 0;

  score_keeper #(
    .WIN_SCORE   (7),
    .HOLD_CYCLES (4),
    .BLINK_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .point_left  (point_left),
    .point_right (point_right),
    .left_score  (left_score),
    .right_score (right_score),
    .display_data(display_data),
    .ball_reset  (ball_reset),
    .serve_left  (serve_left),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag, input int l, input int r, input int d,
                          input int br, input int sl, input int go, input int w);
    checkOutput({tag, ".left"},       12'(left_score),   12'(l));
    checkOutput({tag, ".right"},      12'(right_score),  12'(r));
    checkOutput({tag, ".display"},    display_data,      12'(d));
    checkOutput({tag, ".ball_reset"}, 12'(ball_reset),   12'(br));
    checkOutput({tag, ".serve_left"}, 12'(serve_left),   12'(sl));
    checkOutput({tag, ".game_over"},  12'(game_over),    12'(go));
    checkOutput({tag, ".winner"},     12'(winner),       12'(w));
  endtask

  task automatic applyStimulus(input logic l, input logic r);
    point_left  = l;
    point_right = r;
    tick();
    point_left  = 1'b0;
    point_right = 1'b0;
  endtask

  task automatic holdWait();
    repeat (4) tick();
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    point_left  = 1'b0;
    point_right = 1'b0;
    tick();
    tick();
    checkAll("reset", 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b0;

    $display("[TB] pulses ignored in IDLE");
    applyStimulus(1'b1, 1'b0);
    checkAll("idle_pulse", 0, 0, 0, 1, 0, 0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkAll("start", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] left point then hold with ignored pulses");
    applyStimulus(1'b1, 1'b0);
    checkAll("left1", 1, 0, 100, 1, 0, 0, 0);
    point_right = 1'b1;
    repeat (3) tick();
    checkOutput("hold3.ball_reset", 12'(ball_reset), 12'd1);
    tick();
    point_right = 1'b0;
    checkAll("hold_end", 1, 0, 100, 0, 0, 0, 0);

    $display("[TB] let with serve 0");
    applyStimulus(1'b1, 1'b1);
    checkAll("let0", 1, 0, 100, 1, 0, 0, 0);
    holdWait();
    checkOutput("let0_end.ball_reset", 12'(ball_reset), 12'd0);

    $display("[TB] right scores to seven");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("right_pt.right", 12'(right_score), 12'(i));
      checkOutput("right_pt.display", display_data, 12'(100 + i));
      if (i < 7) begin
        checkOutput("right_pt.serve_left", 12'(serve_left), 12'd1);
        holdWait();
      end
      if (i == 3) begin
        applyStimulus(1'b1, 1'b1);
        checkAll("let1", 1, 3, 103, 1, 1, 0, 0);
        holdWait();
      end
    end
    checkAll("right_win", 1, 7, 107, 1, 1, 1, 1);

    applyStimulus(1'b1, 1'b0);
    checkAll("go_pulse", 1, 7, 107, 1, 1, 1, 1);
    tick();
    checkOutput("go_g2.display", display_data, 12'd107);
    tick();
`ifdef SCORE_BLINK_EN
    checkOutput("go_g3.display", display_data, 12'd0);
`else
    checkOutput("go_g3.display", display_data, 12'd107);
`endif

    $display("[TB] restart with start held");
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checkAll("restart", 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] async reset during hold at 3-2");
    applyStimulus(1'b1, 1'b0);
    holdWait();
    applyStimulus(1'b0, 1'b1);
    holdWait();
    applyStimulus(1'b1, 1'b0);
    holdWait();
    applyStimulus(1'b1, 1'b0);
    holdWait();
    applyStimulus(1'b0, 1'b1);
    checkAll("score32", 3, 2, 302, 1, 1, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    checkAll("async_rst", 0, 0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("post_rst.ball_reset", 12'(ball_reset), 12'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkAll("post_rst_pt", 1, 0, 100, 1, 0, 0, 0);
    repeat (3) tick();
    checkOutput("post_rst_hold3.ball_reset", 12'(ball_reset), 12'd1);
    tick();
    checkOutput("post_rst_hold4.ball_reset", 12'(ball_reset), 12'd0);

    $display("[TB] left wins 7-0");
    for (int i = 2; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("left_pt.left", 12'(left_score), 12'(i));
      if (i < 7) holdWait();
    end
    checkAll("left_win", 7, 0, 700, 1, 0, 1, 0);
    tick();
    tick();
    checkOutput("blink_a.display", display_data, 12'd700);
    tick();
`ifdef SCORE_BLINK_EN
    checkOutput("blink_b.display", display_data, 12'd0);
`else
    checkOutput("blink_b.display", display_data, 12'd700);
`endif
    tick();
    tick();
`ifdef SCORE_BLINK_EN
    checkOutput("blink_c.display", display_data, 12'd0);
`else
    checkOutput("blink_c.display", display_data, 12'd700);
`endif
    tick();
    checkOutput("blink_d.display", display_data, 12'd700);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkAll("final_restart", 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
